// File: rtl/fetch_pc_unit.sv
// Program-counter owner and single-outstanding instruction-fetch sequencer.
// Optional build macro FETCH_ALIGN_CHECK_EN adds redirect alignment checking (fetch_misalign).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h80020000,
    parameter logic [31:0] KSEG_MASK = 32'h80000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] masked_target;
    logic [31:0] target_pc;

    assign masked_target = redirect_target | KSEG_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetch_misalign_q, fetch_misalign_d;

    // Misaligned redirects are forced onto a word boundary and flagged.
    assign target_pc = masked_target & ~32'h3;

    always_comb begin
        fetch_misalign_d = fetch_misalign_q;
        if (redirect_valid) begin
            fetch_misalign_d = |masked_target[1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_misalign_q <= 1'b0;
        end else begin
            fetch_misalign_q <= fetch_misalign_d;
        end
    end

    assign fetch_misalign = fetch_misalign_q;
`else
    assign target_pc = masked_target;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ISSUE;
            pc_q         <= RESET_PC;
            inst_data_q  <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Redirect wins over every other event; a response coinciding with it is dropped.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = target_pc;
                    state_d = imem_rsp_valid ? ISSUE : DROP;
                end else if (imem_rsp_valid) begin
                    inst_data_d  = imem_rsp_data;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target_pc;
                    state_d      = ISSUE;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d    = target_pc;
                    state_d = imem_rsp_valid ? ISSUE : DROP;
                end else if (imem_rsp_valid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_comb begin
        imem_req_valid = reset_n && (state_q == ISSUE) && !redirect_valid;
    end

    assign imem_req_addr = pc_q;
    assign inst_valid    = inst_valid_q;
    assign inst_data     = inst_data_q;
    assign inst_pc       = inst_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit; inputs change on the falling edge,
// outputs are checked 1 time unit later, well before the next rising edge.
module tb_fetch_pc_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fetch_pc_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign  (fetch_misalign)
`endif
    );

    task automatic test_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0h exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h80020000) begin failures++; $display("FAIL reset_addr got=%h exp=80020000", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%0h exp=0", inst_valid); end
        checks++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h/%h exp=0/0", inst_data, inst_pc); end
        @(negedge clock);
        reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80020000) begin failures++; $display("FAIL basic_req got=%0h@%h exp=1@80020000", imem_req_valid, imem_req_addr); end
        @(negedge clock);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h24080001;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL basic_wait_req got=%0h exp=0", imem_req_valid); end
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80020000 || inst_data !== 32'h24080001) begin
            failures++; $display("FAIL basic_inst got=%0h pc=%h data=%h exp=1 pc=80020000 data=24080001", inst_valid, inst_pc, inst_data); end
        $display("basic: inst pc=%h data=%h", inst_pc, inst_data);
        @(negedge clock);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80020004) begin failures++; $display("FAIL basic_next_req got=%0h@%h exp=1@80020004", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_hold_stall();
        @(negedge clock);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAABBCCDD; inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            imem_rsp_valid = 1'b0;
            #1;
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80020004 || inst_data !== 32'hAABBCCDD || imem_req_valid !== 1'b0) begin
                failures++; $display("FAIL stall_cycle%0d got=%0h pc=%h data=%h req=%0h exp=1 pc=80020004 data=aabbccdd req=0", i, inst_valid, inst_pc, inst_data, imem_req_valid); end
        end
        @(negedge clock);
        inst_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_accept_valid got=%0h exp=1", inst_valid); end
        $display("stall: inst pc=%h data=%h accepted", inst_pc, inst_data);
        @(negedge clock);
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80020008) begin
            failures++; $display("FAIL stall_next_req got=%0h req=%0h@%h exp=0 req=1@80020008", inst_valid, imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        @(negedge clock);
        redirect_valid = 1'b1; redirect_target = 32'h00400010;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rw_req_in_redirect got=%0h exp=0", imem_req_valid); end
        @(negedge clock);
        redirect_valid = 1'b0;
        @(negedge clock);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rw_drop got=req%0h inst%0h exp=req0 inst0", imem_req_valid, inst_valid); end
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rw_discard got=%0h exp=0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80400010) begin failures++; $display("FAIL rw_next_req got=%0h@%h exp=1@80400010", imem_req_valid, imem_req_addr); end
        $display("redirect_wait: request at %h", imem_req_addr);
    endtask

    task automatic test_redirect_hold();
        @(negedge clock);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11111111;
        @(negedge clock);
        imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h00001000;
        #1;
        checks++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL rh_pre got=inst%0h req%0h exp=inst1 req0", inst_valid, imem_req_valid); end
        @(negedge clock);
        redirect_valid = 1'b0; imem_req_ready = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rh_killed got=%0h exp=0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80001000) begin failures++; $display("FAIL rh_next_req got=%0h@%h exp=1@80001000", imem_req_valid, imem_req_addr); end
        redirect_valid = 1'b1; redirect_target = 32'h00002000; imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rh_issue_redirect got=%0h exp=0", imem_req_valid); end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80002000) begin failures++; $display("FAIL rh_issue_next got=%0h@%h exp=1@80002000", imem_req_valid, imem_req_addr); end
        $display("redirect_hold: request at %h", imem_req_addr);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h80020000) begin failures++; $display("FAIL rm_async got=%0h@%h exp=0@80020000", imem_req_valid, imem_req_addr); end
        checks++; if (inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rm_inst got=%0h %h %h exp=0 0 0", inst_valid, inst_data, inst_pc); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80020000) begin failures++; $display("FAIL rm_first_req got=%0h@%h exp=1@80020000", imem_req_valid, imem_req_addr); end
        $display("reset_mid: request at %h", imem_req_addr);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_req got=%0h@%h exp=1@fffffffc", imem_req_valid, imem_req_addr); end
        @(negedge clock);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
        @(negedge clock);
        imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_pc !== 32'hFFFFFFFC || inst_data !== 32'h12345678) begin failures++; $display("FAIL wrap_inst got=%h/%h exp=fffffffc/12345678", inst_pc, inst_data); end
        @(negedge clock);
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00000000) begin failures++; $display("FAIL wrap_next got=%0h@%h exp=1@00000000", imem_req_valid, imem_req_addr); end
        $display("wrap: request at %h", imem_req_addr);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        redirect_valid = 1'b1; redirect_target = 32'h00003000;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55555555;
        @(negedge clock);
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80003000) begin
            failures++; $display("FAIL b2b got=inst%0h req%0h@%h exp=inst0 req1@80003000", inst_valid, imem_req_valid, imem_req_addr); end
        $display("back_to_back: request at %h", imem_req_addr);
    endtask

    task automatic test_align();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h00000102;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (fetch_misalign !== 1'b1 || imem_req_addr !== 32'h80000100) begin failures++; $display("FAIL align_set got=%0h@%h exp=1@80000100", fetch_misalign, imem_req_addr); end
`else
        checks++; if (imem_req_addr !== 32'h80000102) begin failures++; $display("FAIL align_passthru got=%h exp=80000102", imem_req_addr); end
`endif
        redirect_valid = 1'b1; redirect_target = 32'h00000200;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL align_clear got=%0h exp=0", fetch_misalign); end
`endif
        checks++; if (imem_req_addr !== 32'h80000200) begin failures++; $display("FAIL align_addr got=%h exp=80000200", imem_req_addr); end
        $display("align: request at %h", imem_req_addr);
        imem_req_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
